// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with a prefetch FIFO, multiple icache requests in flight and redirect squashing.
// Define IFU_PERF_CNT_EN to add the fetch/stall/squash performance counter outputs.
module ifu_prefetch #(
    parameter int unsigned          XLEN      = 32,
    parameter logic [XLEN-1:0]      RESET_PC  = 32'h3000_0000,
    parameter int unsigned          FQ_DEPTH  = 4,
    parameter int unsigned          MAX_OUTST = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_pc_next,
    output logic            req,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_ins,
    output logic            o_valid,
    input  logic            i_post_ready,
    output logic [XLEN-1:0] ins,
`ifdef IFU_PERF_CNT_EN
    output logic [63:0]     o_fetch_cnt,
    output logic [63:0]     o_stall_cnt,
    output logic [31:0]     o_squash_cnt,
`endif
    output logic [XLEN-1:0] pc
);

    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTST) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [OW-1:0]   outst_q, outst_d, squash_q, squash_d;

    logic [XLEN-1:0] fifo_ins_q [FQ_DEPTH];
    logic [XLEN-1:0] fifo_pc_q  [FQ_DEPTH];
    logic [XLEN-1:0] tag_q      [FQ_DEPTH];

    logic [CW:0] occ;
    logic        issue, resp_ok, drop, push, pop;

    always_comb begin
        occ      = (CW+1)'(outst_q) + (CW+1)'(count_q);
        req      = !reset && !i_redirect && (occ < (CW+1)'(FQ_DEPTH)) && (outst_q < OW'(MAX_OUTST));
        req_addr = fetch_pc_q;
        o_valid  = (count_q != '0);
        ins      = o_valid ? fifo_ins_q[rd_ptr_q] : '0;
        pc       = o_valid ? fifo_pc_q[rd_ptr_q]  : '0;
        issue    = req && req_ready;
        // Responses with nothing outstanding are ignored; the tag queue stays aligned with outst.
        resp_ok  = resp_valid && (outst_q != '0);
        drop     = resp_ok && (squash_q != '0);
        push     = resp_ok && (squash_q == '0) && !i_redirect;
        pop      = o_valid && i_post_ready && !i_redirect;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        tag_wr_d   = tag_wr_q + PW'(issue);
        tag_rd_d   = tag_rd_q + PW'(resp_ok);
        outst_d    = outst_q + OW'(issue) - OW'(resp_ok);
        squash_d   = squash_q - OW'(drop);
        if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        // Squash counts already live inside outst, so one formula covers nested redirects.
        if (i_redirect) begin
            fetch_pc_d = i_pc_next;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            squash_d   = outst_q - OW'(resp_ok);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            outst_q    <= '0;
            squash_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            outst_q    <= outst_d;
            squash_q   <= squash_d;
        end
    end

    always_ff @(posedge clock) begin
        if (issue) begin
            tag_q[tag_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            fifo_ins_q[wr_ptr_q] <= resp_ins;
            fifo_pc_q[wr_ptr_q]  <= tag_q[tag_rd_q];
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [63:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
    logic [31:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + 64'(pop);
        stall_cnt_d  = stall_cnt_q + 64'(!o_valid && i_post_ready);
        squash_cnt_d = squash_cnt_q + 32'(drop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign o_fetch_cnt  = fetch_cnt_q;
    assign o_stall_cnt  = stall_cnt_q;
    assign o_squash_cnt = squash_cnt_q;
`endif

    // A response with no request outstanding is an icache protocol violation.
    a_resp_has_outst: assert property (@(posedge clock) disable iff (reset) !(resp_valid && (outst_q == '0)));

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Parametrised instruction fetch unit with a prefetch queue. Replaces the single-request fetch stage.
- Issues sequential fetch requests to the icache, with several requests in flight.
- Buffers returned instructions, each paired with its PC, in a FIFO.
- Hands instructions to decode over a valid/ready handshake.
- Handles redirects from execute by flushing the queue and squashing in-flight responses.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- RESET_PC, 32'h3000_0000, fetch address after reset.
- FQ_DEPTH, 4, prefetch FIFO entries; power of two, >=2.
- MAX_OUTST, 2, maximum icache requests in flight; 1..FQ_DEPTH.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_redirect  in  1  one-cycle redirect strobe from execute/CSR.
- i_pc_next  in  XLEN  redirect target, valid with i_redirect.
- req  out  1  fetch request valid.
- req_ready  in  1  icache accepts the request this cycle.
- req_addr  out  XLEN  fetch address.
- resp_valid  in  1  icache returns one instruction; responses arrive in request order.
- resp_ins  in  XLEN  returned instruction.
- o_valid  out  1  FIFO head valid to decode.
- i_post_ready  in  1  decode accepts the head.
- ins  out  XLEN  head instruction.
- pc  out  XLEN  PC of the head instruction.

Behaviour:
Reset values:
- fetch_pc=RESET_PC; FIFO empty; outst=0; squash=0.
- req=0, o_valid=0, ins=0, pc=0.

Issue:
- req is combinational: req = !i_redirect && (outst + count < FQ_DEPTH) && (outst < MAX_OUTST).
- req_addr = fetch_pc.
- On req && req_ready: fetch_pc += 4 (wraps modulo 2^XLEN), outst++, and fetch_pc is pushed into the PC tag queue.

Response:
- On resp_valid with squash>0: response discarded, squash--, outst--, tag popped.
- On resp_valid with squash==0: {tag, resp_ins} written to the FIFO, outst--, tag popped.
- Credit accounting guarantees the FIFO never overflows.
- resp_valid with outst==0 is illegal: assertion fires; the response is ignored.

Dequeue:
- o_valid = count!=0.
- ins and pc come directly from the FIFO head (zero-latency read).
- The head pops on o_valid && i_post_ready.
- Push and pop in the same cycle leave count unchanged; this holds even when full.

Latency:
- Request to o_valid is the icache latency plus 1 cycle (FIFO write registered).

Redirect (i_redirect=1), applied at the clock edge:
- fetch_pc <= i_pc_next.
- FIFO cleared (count=0, pointers reset); a same-cycle pop and push are ignored.
- squash <= outst - (resp_valid ? 1 : 0). Every response still in flight is dropped.
- req=0 in the redirect cycle.
- Issue resumes the next cycle, from i_pc_next, if credits allow.
- A redirect while squash>0 adds the newly outstanding requests to squash. This is the same formula, since squash counts are part of outst.
- Back-to-back redirects: the last one wins.

Counters:
- count is 0..FQ_DEPTH; outst is 0..MAX_OUTST. Both are clog2+1 wide.
- Both saturate by construction; no wrap-around is permitted.

Reset asserted mid-operation:
- All state returns to reset values immediately.
- Outstanding icache responses arriving after reset are the icache's responsibility; the icache is reset with the same reset.

Optional Feature:
Macro: IFU_PERF_CNT_EN

Defined:
- Adds outputs o_fetch_cnt[63:0], o_stall_cnt[63:0] and o_squash_cnt[31:0]. All reset to 0.
- o_fetch_cnt increments per instruction popped to decode.
- o_stall_cnt increments per cycle with o_valid=0 && i_post_ready=1.
- o_squash_cnt increments per discarded response.

Undefined:
- The ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset release, req_ready=1, 1-cycle icache, i_post_ready=1 -> req_addr 0x30000000, 0x30000004, 0x30000008 on consecutive cycles; decode sees the matching pc/ins in order with one bubble at start.
2. i_post_ready=0 and FQ_DEPTH=4 -> exactly 4 requests issue, then req=0 with o_valid=1 and count=4; after one pop, exactly one new request issues.
3. Two requests in flight (0x30000000, 0x30000004), i_redirect with i_pc_next=0x80000010 -> FIFO emptied, both responses dropped, next req_addr=0x80000010, and the first ins at decode carries pc=0x80000010.
4. Redirect in the same cycle as resp_valid and an o_valid pop, outst=2 -> squash=1; exactly one further response is dropped; no stale entry ever reaches decode.
5. fetch_pc=0xFFFFFFFC, request accepted -> next req_addr=0x00000000 (wrap).
6. With IFU_PERF_CNT_EN: run scenario 3 -> o_squash_cnt=2; o_fetch_cnt equals the number of handshakes counted by the bench.
